pipe_stage_chain: RTL and testbench

- Parametrised successor to the single-stage write-enabled flip-flop.
- Provides a chain of DEPTH N-bit pipeline registers, each with a valid bit, a global advance enable (we) and a synchronous flush.
- Has an optional bubble-collapsing mode, in which empty stages fill even while the output stage is held.
- Used between CPU pipeline sections and for multi-cycle delay lines of the memory/ALU paths.

---
 rtl/pipe_stage_chain_if.sv | 25 ++
 rtl/pipe_stage_chain.sv | 62 ++++++
 tb/tb_pipe_stage_chain.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/pipe_stage_chain_if.sv
// Handshake bundle for pipe_stage_chain: upstream word/valid/ready,
// downstream word/valid/accept, flush and occupancy count.
interface pipe_stage_chain_if #(
    parameter int N     = 32,
    parameter int DEPTH = 2
);
    logic                           we;
    logic                           flush;
    logic                           in_valid;
    logic [N-1:0]                   in;
    logic                           in_ready;
    logic [N-1:0]                   out;
    logic                           out_valid;
    logic [$clog2(DEPTH+1)-1:0]     count;

    modport master (
        output we, flush, in_valid, in,
        input  in_ready, out, out_valid, count
    );

    modport slave (
        input  we, flush, in_valid, in,
        output in_ready, out, out_valid, count
    );
endinterface

// File: rtl/pipe_stage_chain.sv
// Chain of DEPTH valid-tagged N-bit pipeline registers with global advance,
// synchronous flush and an optional bubble-collapsing mode.
module pipe_stage_chain #(
    parameter int N        = 32,
    parameter int DEPTH    = 2,
    parameter bit COLLAPSE = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    pipe_stage_chain_if.slave bus
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [N-1:0]   data_reg [DEPTH];
    logic [DEPTH-1:0] valid_reg;
    logic [DEPTH:0] move;
    logic [CW-1:0]  count_next;

    // A stage may move when downstream advances, or (collapsing) when it
    // holds a bubble that can simply be overwritten.
    always_comb begin
        move = '0;
        move[DEPTH] = bus.we;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (COLLAPSE)
                move[i] = !valid_reg[i] || move[i+1];
            else
                move[i] = bus.we;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || bus.flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_reg[i]  <= '0;
                valid_reg[i] <= 1'b0;
            end
        end else begin
            if (move[0]) begin
                data_reg[0]  <= bus.in;
                valid_reg[0] <= bus.in_valid;
            end
            for (int i = 1; i < DEPTH; i++) begin
                if (move[i]) begin
                    data_reg[i]  <= data_reg[i-1];
                    valid_reg[i] <= valid_reg[i-1];
                end
            end
        end
    end

    always_comb begin
        count_next = '0;
        for (int i = 0; i < DEPTH; i++)
            count_next = count_next + CW'(valid_reg[i]);
    end

    assign bus.in_ready  = move[0];
    assign bus.out       = data_reg[DEPTH-1];
    assign bus.out_valid = valid_reg[DEPTH-1];
    assign bus.count     = count_next;
endmodule

// File: tb/tb_pipe_stage_chain.sv
// Drives three chain configurations with shared stimulus and compares them
// against a stage-array reference model, a vector table and corner sequences.
module tb_pipe_stage_chain;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, flush, we, in_valid;
    logic [7:0] din;

    // c0: DEPTH=3 lock-step, c1: DEPTH=1 legacy, c2: DEPTH=3 collapsing
    pipe_stage_chain_if #(.N(8), .DEPTH(3)) if0 ();
    pipe_stage_chain_if #(.N(8), .DEPTH(1)) if1 ();
    pipe_stage_chain_if #(.N(8), .DEPTH(3)) if2 ();

    assign if0.we = we;  assign if0.flush = flush;  assign if0.in_valid = in_valid;  assign if0.in = din;
    assign if1.we = we;  assign if1.flush = flush;  assign if1.in_valid = in_valid;  assign if1.in = din;
    assign if2.we = we;  assign if2.flush = flush;  assign if2.in_valid = in_valid;  assign if2.in = din;

    pipe_stage_chain #(.N(8), .DEPTH(3), .COLLAPSE(1'b0)) dut0 (.clk(clk), .reset(reset), .bus(if0));
    pipe_stage_chain #(.N(8), .DEPTH(1), .COLLAPSE(1'b0)) dut1 (.clk(clk), .reset(reset), .bus(if1));
    pipe_stage_chain #(.N(8), .DEPTH(3), .COLLAPSE(1'b1)) dut2 (.clk(clk), .reset(reset), .bus(if2));

    localparam int NC = 3;
    logic [7:0]  o_out [NC];
    logic        o_ov  [NC];
    logic        o_rdy [NC];
    logic [31:0] o_cnt [NC];
    assign o_out[0] = if0.out;  assign o_ov[0] = if0.out_valid;  assign o_rdy[0] = if0.in_ready;  assign o_cnt[0] = 32'(if0.count);
    assign o_out[1] = if1.out;  assign o_ov[1] = if1.out_valid;  assign o_rdy[1] = if1.in_ready;  assign o_cnt[1] = 32'(if1.count);
    assign o_out[2] = if2.out;  assign o_ov[2] = if2.out_valid;  assign o_rdy[2] = if2.in_ready;  assign o_cnt[2] = 32'(if2.count);

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    int         dep [NC] = '{3, 1, 3};
    bit         col [NC] = '{1'b0, 1'b0, 1'b1};
    logic [7:0] md  [NC][3];
    bit         mv  [NC][3];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Input accepted iff downstream advances, or (collapsing) any stage is empty.
    function automatic bit model_ready(int c);
        if (we) return 1'b1;
        if (!col[c]) return 1'b0;
        for (int i = 0; i < dep[c]; i++)
            if (!mv[c][i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int model_count(int c);
        int n = 0;
        for (int i = 0; i < dep[c]; i++) n += int'(mv[c][i]);
        return n;
    endfunction

    // Stages from the input up to the highest stage allowed to move all shift by one.
    task automatic model_step();
        for (int c = 0; c < NC; c++) begin
            if (reset || flush) begin
                for (int i = 0; i < 3; i++) begin md[c][i] = 8'h00; mv[c][i] = 1'b0; end
            end else begin
                int k = -1;
                if (we) k = dep[c] - 1;
                else if (col[c])
                    for (int i = 0; i < dep[c]; i++) if (!mv[c][i]) k = i;
                for (int i = k; i >= 1; i--) begin
                    md[c][i] = md[c][i-1];
                    mv[c][i] = mv[c][i-1];
                end
                if (k >= 0) begin md[c][0] = din; mv[c][0] = in_valid; end
            end
        end
    endtask

    task automatic tick();
        bit exp_rdy [NC];
        #1;
        for (int c = 0; c < NC; c++) begin
            exp_rdy[c] = model_ready(c);
            chk($sformatf("in_ready c%0d", c), 32'(o_rdy[c]), 32'(exp_rdy[c]));
        end
        @(posedge clk);
        model_step();
        cyc++;
        #1;
        for (int c = 0; c < NC; c++) begin
            chk($sformatf("out c%0d", c), 32'(o_out[c]), 32'(md[c][dep[c]-1]));
            chk($sformatf("out_valid c%0d", c), 32'(o_ov[c]), 32'(mv[c][dep[c]-1]));
            chk($sformatf("count c%0d", c), o_cnt[c], 32'(model_count(c)));
        end
        $display("cyc %0d rst=%0b fl=%0b we=%0b iv=%0b in=%02h | c0 %02h/%0b/%0d c1 %02h/%0b/%0d c2 %02h/%0b/%0d",
                 cyc, reset, flush, we, in_valid, din,
                 o_out[0], o_ov[0], o_cnt[0], o_out[1], o_ov[1], o_cnt[1], o_out[2], o_ov[2], o_cnt[2]);
    endtask

    task automatic drive(input bit r, input bit f, input bit w, input bit v, input logic [7:0] d);
        reset = r; flush = f; we = w; in_valid = v; din = d;
    endtask

    typedef struct {
        bit         rst, fl, w, iv;
        logic [7:0] d;
        logic [7:0] eo;
        bit         eov;
        int         ecnt;
    } vec_t;

    vec_t vecs [16];

    initial begin
        for (int c = 0; c < NC; c++)
            for (int i = 0; i < 3; i++) begin md[c][i] = 8'h00; mv[c][i] = 1'b0; end
        drive(1, 0, 1, 1, 8'hAA);

        // Expectations for c0 (DEPTH=3, lock-step): reset, streaming, flush priority
        vecs[0]  = '{1, 0, 1, 1, 8'hAA, 8'h00, 0, 0};
        vecs[1]  = '{1, 0, 1, 1, 8'hAA, 8'h00, 0, 0};
        vecs[2]  = '{0, 0, 1, 1, 8'h11, 8'h00, 0, 1};
        vecs[3]  = '{0, 0, 1, 1, 8'h22, 8'h00, 0, 2};
        vecs[4]  = '{0, 0, 1, 1, 8'h33, 8'h11, 1, 3};
        vecs[5]  = '{0, 0, 1, 1, 8'h44, 8'h22, 1, 3};
        vecs[6]  = '{0, 0, 1, 0, 8'h00, 8'h33, 1, 2};
        vecs[7]  = '{0, 0, 1, 0, 8'h00, 8'h44, 1, 1};
        vecs[8]  = '{0, 0, 1, 0, 8'h00, 8'h00, 0, 0};
        vecs[9]  = '{0, 0, 1, 1, 8'h55, 8'h00, 0, 1};
        vecs[10] = '{0, 0, 1, 1, 8'h66, 8'h00, 0, 2};
        vecs[11] = '{0, 0, 1, 1, 8'h77, 8'h55, 1, 3};
        vecs[12] = '{0, 1, 1, 1, 8'h88, 8'h00, 0, 0};
        vecs[13] = '{0, 0, 1, 0, 8'h00, 8'h00, 0, 0};
        vecs[14] = '{0, 0, 1, 0, 8'h00, 8'h00, 0, 0};
        vecs[15] = '{0, 0, 1, 0, 8'h00, 8'h00, 0, 0};

        foreach (vecs[n]) begin
            drive(vecs[n].rst, vecs[n].fl, vecs[n].w, vecs[n].iv, vecs[n].d);
            tick();
            chk($sformatf("vec%0d out", n), 32'(o_out[0]), 32'(vecs[n].eo));
            chk($sformatf("vec%0d out_valid", n), 32'(o_ov[0]), 32'(vecs[n].eov));
            chk($sformatf("vec%0d count", n), o_cnt[0], 32'(vecs[n].ecnt));
        end

        // Legacy single-stage stall and reset
        drive(1, 0, 1, 0, 8'h00); tick();
        drive(0, 0, 1, 1, 8'hAA); tick();
        chk("legacy capture", 32'(o_out[1]), 32'h0000_00AA);
        drive(0, 0, 0, 1, 8'hBB); #1;
        chk("legacy in_ready stall", 32'(o_rdy[1]), 32'd0);
        tick();
        chk("legacy hold", 32'(o_out[1]), 32'h0000_00AA);
        drive(1, 0, 1, 1, 8'hBB); tick();
        chk("legacy reset", 32'(o_out[1]), 32'd0);

        // Bubble collapse while the output stage is held
        drive(1, 0, 0, 0, 8'h00); tick();
        drive(0, 0, 0, 1, 8'h01); tick();
        drive(0, 0, 0, 1, 8'h02); tick();
        drive(0, 0, 0, 1, 8'h03); tick();
        chk("collapse out", 32'(o_out[2]), 32'h01);
        chk("collapse count", o_cnt[2], 32'd3);
        chk("lockstep count", o_cnt[0], 32'd0);
        #1;
        chk("collapse full in_ready", 32'(o_rdy[2]), 32'd0);
        drive(0, 0, 1, 0, 8'h00); tick();
        chk("collapse order 2", 32'(o_out[2]), 32'h02);
        tick();
        chk("collapse order 3", 32'(o_out[2]), 32'h03);

        // Reset together with flush mid-stream, then resume
        drive(1, 0, 1, 0, 8'h00); tick();
        drive(0, 0, 1, 1, 8'hA1); tick();
        drive(0, 0, 1, 1, 8'hA2); tick();
        drive(1, 1, 1, 1, 8'hA3); tick();
        chk("rst+flush count c0", o_cnt[0], 32'd0);
        chk("rst+flush out_valid c0", 32'(o_ov[0]), 32'd0);
        chk("rst+flush count c2", o_cnt[2], 32'd0);
        drive(0, 0, 1, 1, 8'hB1); #1;
        chk("resume in_ready c0", 32'(o_rdy[0]), 32'd1);
        tick();
        chk("resume count c0", o_cnt[0], 32'd1);
        chk("resume out c1", 32'(o_out[1]), 32'h0000_00B1);

        // Randomized traffic against the reference model
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 59) == 0, $urandom_range(0, 29) == 0,
                  $urandom_range(0, 9) < 6, $urandom_range(0, 3) != 0, 8'($urandom));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
